// File: rtl/df_fifo_pkg.sv
// Shared types and helpers for the dataflow stream FIFO: flag bundle, statistics width, pointer wrap rule.
package df_fifo_pkg;

  localparam int STAT_CNT_WIDTH = 32;

  typedef struct packed {
    logic full_n;
    logic empty_n;
  } fifo_flags_t;

  // Compare-and-wrap so non-power-of-two depths never index past the last entry.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/df_fifo_ptr.sv
// Wrap-around index counter used for both the write and the read side of the FIFO.
module df_fifo_ptr
  import df_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= PTR_W'(ptr_next(32'(ptr), 32'(DEPTH)));
    end
  end

endmodule

// File: rtl/df_stream_fifo.sv
// First-word-fall-through ap_fifo channel between two dataflow processes.
// Optional statistics outputs (hwm, block counters) are built when DF_STREAM_FIFO_STATS_EN is defined.
module df_stream_fifo
  import df_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  wr_fire,
  output logic                  rd_fire,
  output logic [CNT_WIDTH-1:0]  occupancy
`ifdef DF_STREAM_FIFO_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]      hwm,
  output logic [STAT_CNT_WIDTH-1:0] wr_block_cycles,
  output logic [STAT_CNT_WIDTH-1:0] rd_block_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  fifo_flags_t           flags;

  // Flags decode straight from the registered count, so they never glitch.
  assign flags.full_n  = (count != CNT_WIDTH'(DEPTH));
  assign flags.empty_n = (count != '0);

  assign if_full_n  = flags.full_n;
  assign if_empty_n = flags.empty_n;
  assign wr_fire    = if_write & if_write_ce & flags.full_n;
  assign rd_fire    = if_read & if_read_ce & flags.empty_n;
  assign occupancy  = count;
  assign if_dout    = mem[rd_ptr];

  df_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clock  (clock),
    .reset  (reset),
    .advance(wr_fire),
    .ptr    (wr_ptr)
  );

  df_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clock  (clock),
    .reset  (reset),
    .advance(rd_fire),
    .ptr    (rd_ptr)
  );

  // Storage is never cleared; a write strobe during reset is simply dropped.
  always_ff @(posedge clock) begin
    if (reset && wr_fire) begin
      mem[wr_ptr] <= if_din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (wr_fire && !rd_fire) begin
      count <= count + 1'b1;
    end else if (rd_fire && !wr_fire) begin
      count <= count - 1'b1;
    end
  end

`ifdef DF_STREAM_FIFO_STATS_EN
  logic wr_blocked;
  logic rd_blocked;

  assign wr_blocked = if_write & if_write_ce & ~flags.full_n;
  assign rd_blocked = if_read & if_read_ce & ~flags.empty_n;

  // Block counters stick at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hwm             <= '0;
      wr_block_cycles <= '0;
      rd_block_cycles <= '0;
    end else begin
      if (count > hwm) begin
        hwm <= count;
      end
      if (wr_blocked && (wr_block_cycles != '1)) begin
        wr_block_cycles <= wr_block_cycles + 1'b1;
      end
      if (rd_blocked && (rd_block_cycles != '1)) begin
        rd_block_cycles <= rd_block_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_df_stream_fifo.sv
// Directed bench for df_stream_fifo: vector table for fill/drain/simultaneous cases, hand sequences for reset, wrap and stats.
module tb_df_stream_fifo;

  logic        clock = 1'b0;
  logic        reset;

  logic        wce, wr, rce, rd;
  logic [31:0] din;
  logic        full_n, empty_n, wf, rf;
  logic [31:0] dout;
  logic [2:0]  occ;

  logic        wce3, wr3, rce3, rd3;
  logic [31:0] din3;
  logic        full_n3, empty_n3, wf3, rf3;
  logic [31:0] dout3;
  logic [1:0]  occ3;

`ifdef DF_STREAM_FIFO_STATS_EN
  logic [2:0]  hwm;
  logic [31:0] wblk, rblk;
  logic [1:0]  hwm3;
  logic [31:0] wblk3, rblk3;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  df_stream_fifo #(.DATA_WIDTH(32), .DEPTH(4)) u (
    .clock(clock), .reset(reset),
    .if_write_ce(wce), .if_write(wr), .if_din(din), .if_full_n(full_n),
    .if_read_ce(rce), .if_read(rd), .if_dout(dout), .if_empty_n(empty_n),
    .wr_fire(wf), .rd_fire(rf), .occupancy(occ)
`ifdef DF_STREAM_FIFO_STATS_EN
    , .hwm(hwm), .wr_block_cycles(wblk), .rd_block_cycles(rblk)
`endif
  );

  df_stream_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u3 (
    .clock(clock), .reset(reset),
    .if_write_ce(wce3), .if_write(wr3), .if_din(din3), .if_full_n(full_n3),
    .if_read_ce(rce3), .if_read(rd3), .if_dout(dout3), .if_empty_n(empty_n3),
    .wr_fire(wf3), .rd_fire(rf3), .occupancy(occ3)
`ifdef DF_STREAM_FIFO_STATS_EN
    , .hwm(hwm3), .wr_block_cycles(wblk3), .rd_block_cycles(rblk3)
`endif
  );

  typedef struct {
    logic        wce, wr, rce, rd;
    logic [31:0] din;
    logic        e_wf, e_rf, chk_d;
    logic [31:0] e_dout;
    logic [2:0]  e_occ;
    logic        e_fn, e_en;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic a_wce, logic a_wr, logic a_rce, logic a_rd, logic [31:0] a_din,
                              logic a_wf, logic a_rf, logic a_chk, logic [31:0] a_dout,
                              logic [2:0] a_occ, logic a_fn, logic a_en);
    vec_t r;
    r.wce = a_wce; r.wr = a_wr; r.rce = a_rce; r.rd = a_rd; r.din = a_din;
    r.e_wf = a_wf; r.e_rf = a_rf; r.chk_d = a_chk; r.e_dout = a_dout;
    r.e_occ = a_occ; r.e_fn = a_fn; r.e_en = a_en;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic a_wr, input logic a_rd, input logic [31:0] a_din);
    wce = 1'b1; rce = 1'b1; wr = a_wr; rd = a_rd; din = a_din;
  endtask

  initial begin
    int cnt, nw, nr;
    logic ewf, erf;

    reset = 1'b0;
    wce = 0; wr = 0; rce = 0; rd = 0; din = 0;
    wce3 = 1; wr3 = 0; rce3 = 1; rd3 = 0; din3 = 0;

    // Reset for three cycles, with a write request pending in the last one.
    step();
    step();
    drive(1'b1, 1'b0, 32'hDEAD);
    step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    #1;
    chk("reset_full_n", 32'(full_n), 32'd1);
    chk("reset_empty_n", 32'(empty_n), 32'd0);
    chk("reset_occ", 32'(occ), 32'd0);
    chk("reset_occ3", 32'(occ3), 32'd0);

    // wce wr rce rd din | wf rf chk dout | occ fn en
    tbl.push_back(mk(1,1,1,0,32'h11, 1,0,0,32'h0,  3'd1,1,1));
    tbl.push_back(mk(1,1,1,0,32'h22, 1,0,1,32'h11, 3'd2,1,1));
    tbl.push_back(mk(1,1,1,0,32'h33, 1,0,1,32'h11, 3'd3,1,1));
    tbl.push_back(mk(1,1,1,0,32'h44, 1,0,1,32'h11, 3'd4,0,1));
    tbl.push_back(mk(1,1,1,0,32'h55, 0,0,1,32'h11, 3'd4,0,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'h11, 3'd3,1,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'h22, 3'd2,1,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'h33, 3'd1,1,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'h44, 3'd0,1,0));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,0,0,32'h0,  3'd0,1,0));
    tbl.push_back(mk(0,1,1,0,32'h99, 0,0,0,32'h0,  3'd0,1,0));
    tbl.push_back(mk(1,1,1,0,32'hA1, 1,0,0,32'h0,  3'd1,1,1));
    tbl.push_back(mk(1,1,1,0,32'hA2, 1,0,1,32'hA1, 3'd2,1,1));
    tbl.push_back(mk(1,1,1,0,32'hA3, 1,0,1,32'hA1, 3'd3,1,1));
    tbl.push_back(mk(1,1,1,0,32'hA4, 1,0,1,32'hA1, 3'd4,0,1));
    tbl.push_back(mk(1,1,1,1,32'hB5, 0,1,1,32'hA1, 3'd3,1,1));
    tbl.push_back(mk(1,1,1,1,32'hB6, 1,1,1,32'hA2, 3'd3,1,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'hA3, 3'd2,1,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'hA4, 3'd1,1,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'hB6, 3'd0,1,0));
    tbl.push_back(mk(1,1,1,1,32'hC7, 1,0,0,32'h0,  3'd1,1,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'hC7, 3'd0,1,0));
    tbl.push_back(mk(1,1,1,0,32'hD8, 1,0,0,32'h0,  3'd1,1,1));
    tbl.push_back(mk(1,0,0,1,32'h0,  0,0,1,32'hD8, 3'd1,1,1));
    tbl.push_back(mk(1,0,1,1,32'h0,  0,1,1,32'hD8, 3'd0,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      wce = tbl[i].wce; wr = tbl[i].wr; rce = tbl[i].rce; rd = tbl[i].rd; din = tbl[i].din;
      #1;
      chk($sformatf("v%0d_wr_fire", i), 32'(wf), 32'(tbl[i].e_wf));
      chk($sformatf("v%0d_rd_fire", i), 32'(rf), 32'(tbl[i].e_rf));
      if (tbl[i].chk_d) chk($sformatf("v%0d_dout", i), dout, tbl[i].e_dout);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_occ", i), 32'(occ), 32'(tbl[i].e_occ));
      chk($sformatf("v%0d_full_n", i), 32'(full_n), 32'(tbl[i].e_fn));
      chk($sformatf("v%0d_empty_n", i), 32'(empty_n), 32'(tbl[i].e_en));
    end

    // Reset in the middle of operation with two entries held.
    drive(1'b1, 1'b0, 32'h01); step();
    drive(1'b1, 1'b0, 32'h02); step();
    chk("mid_occ_before", 32'(occ), 32'd2);
    drive(1'b0, 1'b0, 32'h0);
    reset = 1'b0; step(); reset = 1'b1;
    chk("mid_occ", 32'(occ), 32'd0);
    chk("mid_empty_n", 32'(empty_n), 32'd0);
    chk("mid_full_n", 32'(full_n), 32'd1);
    drive(1'b1, 1'b0, 32'hAB); step();
    drive(1'b0, 1'b1, 32'h0);
    #1;
    chk("mid_dout", dout, 32'hAB);
    chk("mid_rd_fire", 32'(rf), 32'd1);
    step();
    chk("mid_occ_after", 32'(occ), 32'd0);
    drive(1'b0, 1'b0, 32'h0);

`ifdef DF_STREAM_FIFO_STATS_EN
    reset = 1'b0; step(); reset = 1'b1;
    chk("stat_hwm_reset", 32'(hwm), 32'd0);
    chk("stat_wblk_reset", wblk, 32'd0);
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 32'(i)); step(); end
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 32'hEE); step(); end
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 32'h0); step(); end
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b1, 32'h0); step(); end
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk("stat_wr_block", wblk, 32'd5);
    chk("stat_rd_block", rblk, 32'd3);
    chk("stat_hwm", 32'(hwm), 32'd4);
`endif

    // DEPTH=3 stream with random duty; ten words force both pointers around the wrap.
    cnt = 0; nw = 1; nr = 1;
    for (int cyc = 0; cyc < 400 && nr <= 10; cyc++) begin
      wr3 = (nw <= 10) && ($urandom_range(0, 1) == 1);
      rd3 = ($urandom_range(0, 1) == 1);
      din3 = 32'(nw);
      #1;
      ewf = wr3 && (cnt != 3);
      erf = rd3 && (cnt != 0);
      chk("wrap_wr_fire", 32'(wf3), 32'(ewf));
      chk("wrap_rd_fire", 32'(rf3), 32'(erf));
      if (erf) chk("wrap_dout", dout3, 32'(nr));
      @(posedge clock);
      #1;
      if (ewf) nw++;
      if (erf) nr++;
      cnt = cnt + int'(ewf) - int'(erf);
      chk("wrap_occ", 32'(occ3), 32'(cnt));
    end
    wr3 = 0; rd3 = 0;
    chk("wrap_all_read", 32'(nr), 32'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
